// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX channel.
//   tx_seq_state_t : sequencer FSM states
//   UART_CNT_LSB/MSB : position of the 2-bit byte count in a packed TX word
//   UART_PAYLOAD_W   : width of the packed payload, LSB byte first
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StLoad,
    StSend
  } tx_seq_state_t;

  localparam int unsigned UART_CNT_LSB   = 26;
  localparam int unsigned UART_CNT_MSB   = 27;
  localparam int unsigned UART_PAYLOAD_W = 24;

endpackage

// File: rtl/uart_tx_sequencer.sv
// Moves packed TX words from the TX FIFO into the unpacking register and streams the
// resulting bytes into the UART transmitter.
//   clk, rst          : clock, synchronous active-high reset
//   enable, flush     : allow new fetches; one-cycle abort of the current word
//   fifo_empty/rden/rdata : TX FIFO pop interface (rdata valid FIFO_RD_LAT cycles after rden)
//   reg_wren/din      : load strobe and word to the unpacker
//   reg_rden/dout/valid : unpacker advance strobe, current byte, byte-pending flag
//   tx_valid/data/ready : ready/valid handshake to the transmitter
//   busy, bytes_sent  : status (not IDLE; count of accepted bytes, wrapping)
module uart_tx_sequencer
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_RD_LAT = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             flush,
  input  logic             fifo_empty,
  output logic             fifo_rden,
  input  logic [31:0]      fifo_rdata,
  output logic             reg_wren,
  output logic [31:0]      reg_din,
  output logic             reg_rden,
  input  logic [7:0]       reg_dout,
  input  logic             reg_valid,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bytes_sent
);

  localparam int unsigned     LatW    = (FIFO_RD_LAT > 1) ? $clog2(FIFO_RD_LAT) : 1;
  localparam logic [LatW-1:0] LatLast = LatW'(FIFO_RD_LAT - 1);

  tx_seq_state_t    r_state;
  logic [LatW-1:0]  r_lat_cnt;
  logic             r_drop;     // flush arrived in an earlier FETCH cycle
  logic [31:0]      r_din;
  logic [CNT_W-1:0] r_cnt;

  logic w_can_fetch;
  logic w_in_send;
  logic w_hs;
  logic w_word_done;

  assign w_can_fetch = enable && !fifo_empty;
  assign w_in_send   = (r_state == StSend);
  assign w_hs        = w_in_send && reg_valid && tx_ready;
  assign w_word_done = w_in_send && !reg_valid;

  // Pop is combinational so it coincides with the transition into FETCH.
  always_comb begin
    fifo_rden = 1'b0;
    if (!rst && w_can_fetch) begin
      if (r_state == StIdle) begin
        fifo_rden = 1'b1;
      end else if (w_word_done && !flush) begin
        fifo_rden = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_lat_cnt <= '0;
      r_drop    <= 1'b0;
      r_din     <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_hs) begin
        r_cnt <= r_cnt + 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (fifo_rden) begin
            r_state   <= StFetch;
            r_lat_cnt <= LatLast;
            r_drop    <= 1'b0;
          end
        end
        StFetch: begin
          if (r_lat_cnt == '0) begin
            // The in-flight word is always captured; a flush only skips the load.
            r_din   <= fifo_rdata;
            r_state <= (r_drop || flush) ? StIdle : StLoad;
            r_drop  <= 1'b0;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
            if (flush) begin
              r_drop <= 1'b1;
            end
          end
        end
        StLoad: begin
          r_state <= flush ? StIdle : StSend;
        end
        StSend: begin
          if (flush) begin
            r_state <= StIdle;
          end else if (w_word_done) begin
            if (fifo_rden) begin
              r_state   <= StFetch;
              r_lat_cnt <= LatLast;
              r_drop    <= 1'b0;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign reg_wren   = (r_state == StLoad);
  assign reg_rden   = w_hs;
  assign reg_din    = r_din;
  // Gating by state keeps stale unpacker contents off the line after reset or flush.
  assign tx_valid   = w_in_send && reg_valid;
  assign tx_data    = w_in_send ? reg_dout : 8'h00;
  assign busy       = (r_state != StIdle);
  assign bytes_sent = r_cnt;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: two instances (FIFO_RD_LAT=1/CNT_W=4, FIFO_RD_LAT=2/CNT_W=16),
// each with a behavioural TX FIFO and unpacker. Expected bytes come from the words pushed.
module tb_uart_tx_sequencer;
  import uart_pkg::*;

  localparam int NumDut = 2;
  localparam int FifoAw = 6;
  localparam int ExpAw  = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst, enable, flush, tx_ready;
  logic [1:0]  fifo_empty, fifo_rden, reg_wren, reg_rden, reg_valid, tx_valid, busy;
  logic [31:0] fifo_rdata [NumDut];
  logic [31:0] reg_din    [NumDut];
  logic [7:0]  reg_dout   [NumDut];
  logic [7:0]  tx_data    [NumDut];
  logic [3:0]  cnt0;
  logic [15:0] cnt1;

  uart_tx_sequencer #(.FIFO_RD_LAT(1), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst(rst[0]), .enable(enable[0]), .flush(flush[0]),
    .fifo_empty(fifo_empty[0]), .fifo_rden(fifo_rden[0]), .fifo_rdata(fifo_rdata[0]),
    .reg_wren(reg_wren[0]), .reg_din(reg_din[0]), .reg_rden(reg_rden[0]),
    .reg_dout(reg_dout[0]), .reg_valid(reg_valid[0]), .tx_valid(tx_valid[0]),
    .tx_data(tx_data[0]), .tx_ready(tx_ready[0]), .busy(busy[0]), .bytes_sent(cnt0)
  );

  uart_tx_sequencer #(.FIFO_RD_LAT(2), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst[1]), .enable(enable[1]), .flush(flush[1]),
    .fifo_empty(fifo_empty[1]), .fifo_rden(fifo_rden[1]), .fifo_rdata(fifo_rdata[1]),
    .reg_wren(reg_wren[1]), .reg_din(reg_din[1]), .reg_rden(reg_rden[1]),
    .reg_dout(reg_dout[1]), .reg_valid(reg_valid[1]), .tx_valid(tx_valid[1]),
    .tx_data(tx_data[1]), .tx_ready(tx_ready[1]), .busy(busy[1]), .bytes_sent(cnt1)
  );

  // ---------------- environment models: TX FIFO and 24-to-8 unpacker ----------------
  logic [31:0] fifo_mem [NumDut][2**FifoAw];
  int          fifo_wr  [NumDut];
  int          fifo_rd  [NumDut];
  logic [31:0] rd_p1    [NumDut];
  logic [31:0] rd_p2    [NumDut];
  logic [7:0]  up_byte  [NumDut][4];
  logic [1:0]  up_n     [NumDut];
  logic [1:0]  up_idx   [NumDut];

  always_comb begin
    for (int g = 0; g < NumDut; g++) begin
      fifo_empty[g] = (fifo_wr[g] == fifo_rd[g]);
      fifo_rdata[g] = (g == 0) ? rd_p1[g] : rd_p2[g];
      reg_valid[g]  = (up_idx[g] < up_n[g]);
      reg_dout[g]   = reg_valid[g] ? up_byte[g][up_idx[g]] : 8'h00;
    end
  end

  // Read data is garbage except in the exact cycle the latency promises.
  always @(posedge clk) begin
    for (int g = 0; g < NumDut; g++) begin
      if (fifo_rden[g]) begin
        rd_p1[g]   <= fifo_mem[g][FifoAw'(fifo_rd[g])];
        fifo_rd[g] <= fifo_rd[g] + 1;
      end else begin
        rd_p1[g] <= $urandom;
      end
      rd_p2[g] <= rd_p1[g];
      if (reg_wren[g]) begin
        for (int b = 0; b < int'(UART_PAYLOAD_W / 8); b++) begin
          up_byte[g][b] <= reg_din[g][8*b +: 8];
        end
        up_n[g]   <= reg_din[g][UART_CNT_MSB:UART_CNT_LSB];
        up_idx[g] <= 2'd0;
      end else if (reg_rden[g]) begin
        up_idx[g] <= up_idx[g] + 2'd1;
      end
    end
  end

  // ---------------- reference model and checking ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q     [NumDut][2**ExpAw];
  int          exp_wr    [NumDut];
  int          exp_rd    [NumDut];
  int          exp_total [NumDut];

  logic [1:0]  s_rden, s_wren, s_rrden, s_valid, s_busy, prev_stall;
  logic [7:0]  s_data    [NumDut];
  logic [31:0] s_din     [NumDut];
  logic [15:0] s_cnt     [NumDut];
  logic [7:0]  prev_data [NumDut];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic string tag(input string s, input int g);
    return $sformatf("%s/dut%0d", s, g);
  endfunction

  function automatic int lat(input int g);
    return g + 1;
  endfunction

  function automatic int cnt_mod(input int g);
    return (g == 0) ? 16 : 65536;
  endfunction

  task automatic monitor();
    for (int g = 0; g < NumDut; g++) begin
      logic        hs;
      logic [31:0] want;
      hs         = tx_valid[g] && tx_ready[g];
      s_rden[g]  = fifo_rden[g];
      s_wren[g]  = reg_wren[g];
      s_rrden[g] = reg_rden[g];
      s_valid[g] = tx_valid[g];
      s_busy[g]  = busy[g];
      s_data[g]  = tx_data[g];
      s_din[g]   = reg_din[g];
      s_cnt[g]   = (g == 0) ? {12'h000, cnt0} : cnt1;
      if (hs) begin
        // 0x100 cannot match a byte: a handshake with nothing expected is an error.
        want = (exp_rd[g] < exp_wr[g]) ? {24'h0, exp_q[g][ExpAw'(exp_rd[g])]} : 32'h100;
        check_eq(tag("tx_byte", g), {24'h0, tx_data[g]}, want);
        exp_rd[g]++;
      end
      check_eq(tag("rden_is_hs", g), 32'(reg_rden[g]), 32'(hs));
      if (reg_wren[g]) check_eq(tag("wren_rden_excl", g), 32'(reg_rden[g]), 0);
      if (fifo_rden[g]) check_eq(tag("pop_nonempty", g), 32'(fifo_empty[g]), 0);
      if (prev_stall[g]) begin
        check_eq(tag("stall_valid", g), 32'(tx_valid[g]), 1);
        check_eq(tag("stall_data", g), 32'(tx_data[g]), 32'(prev_data[g]));
      end
      prev_stall[g] = tx_valid[g] && !tx_ready[g] && !flush[g] && !rst[g];
      prev_data[g]  = tx_data[g];
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word(input int cnt);
    logic [31:0] w;
    w = $urandom;
    w[UART_CNT_MSB:UART_CNT_LSB] = 2'(cnt);
    return w;
  endfunction

  task automatic expect_byte(input int g, input logic [7:0] b);
    exp_q[g][ExpAw'(exp_wr[g])] = b;
    exp_wr[g]++;
    exp_total[g]++;
  endtask

  task automatic push_word(input int g, input logic [31:0] w, input bit expect_all);
    fifo_mem[g][FifoAw'(fifo_wr[g])] = w;
    fifo_wr[g]++;
    if (expect_all) begin
      for (int b = 0; b < int'(w[UART_CNT_MSB:UART_CNT_LSB]); b++) expect_byte(g, w[8*b +: 8]);
    end
  endtask

  task automatic do_reset(input int g);
    enable[g]   = 1'b0;
    flush[g]    = 1'b0;
    tx_ready[g] = 1'b0;
    rst[g]      = 1'b1;
    cycle();
    cycle();
    check_eq(tag("rst_fifo_rden", g), 32'(s_rden[g]), 0);
    check_eq(tag("rst_reg_wren", g), 32'(s_wren[g]), 0);
    check_eq(tag("rst_reg_rden", g), 32'(s_rrden[g]), 0);
    check_eq(tag("rst_tx_valid", g), 32'(s_valid[g]), 0);
    check_eq(tag("rst_busy", g), 32'(s_busy[g]), 0);
    check_eq(tag("rst_reg_din", g), s_din[g], 0);
    check_eq(tag("rst_tx_data", g), 32'(s_data[g]), 0);
    check_eq(tag("rst_bytes_sent", g), 32'(s_cnt[g]), 0);
    rst[g]       = 1'b0;
    fifo_wr[g]   = fifo_rd[g];
    exp_rd[g]    = exp_wr[g];
    exp_total[g] = 0;
  endtask

  task automatic wait_drain(input int g, input int budget);
    logic done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      cycle();
      done = !s_busy[g] && !s_rden[g] && (fifo_empty[g] || !enable[g]);
    end
    check_eq(tag("drain_in_budget", g), 32'(done), 1);
  endtask

  task automatic wait_pop(input int g);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      cycle();
      seen = s_rden[g];
    end
    check_eq(tag("pop_seen", g), 32'(seen), 1);
  endtask

  task automatic wait_valid(input int g);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      cycle();
      seen = s_valid[g];
    end
    check_eq(tag("valid_seen", g), 32'(seen), 1);
  endtask

  task automatic end_check(input int g);
    check_eq(tag("all_bytes_out", g), exp_rd[g], exp_wr[g]);
    check_eq(tag("bytes_sent", g), 32'(s_cnt[g]), 32'(exp_total[g] % cnt_mod(g)));
    check_eq(tag("idle_busy", g), 32'(s_busy[g]), 0);
  endtask

  task automatic timed_word(input int g, input logic [31:0] w, input int nbytes);
    int k;
    int run;
    push_word(g, w, 1'b1);
    tx_ready[g] = 1'b1;
    enable[g]   = 1'b1;
    wait_pop(g);
    k = 0;
    do begin
      cycle();
      k++;
    end while (!s_valid[g] && k < 20);
    check_eq(tag("first_byte_latency", g), k, lat(g) + 2);
    run = 0;
    while (s_valid[g] && run < 8) begin
      run++;
      cycle();
    end
    check_eq(tag("burst_len", g), run, nbytes);
    wait_drain(g, 50);
    end_check(g);
  endtask

  task automatic flush_at(input int g, input int j);
    int wr;
    push_word(g, rand_word(3), 1'b0);
    tx_ready[g] = 1'b1;
    enable[g]   = 1'b1;
    wait_pop(g);
    wr = 0;
    for (int i = 1; i < j; i++) begin
      cycle();
      wr += int'(s_wren[g]);
    end
    flush[g] = 1'b1;
    cycle();
    flush[g] = 1'b0;
    wr += int'(s_wren[g]);
    for (int i = 0; i < 6; i++) begin
      cycle();
      wr += int'(s_wren[g]);
    end
    check_eq(tag("wren_count_flush", g), wr, (j == lat(g) + 1) ? 1 : 0);
    check_eq(tag("idle_after_flush", g), 32'(s_busy[g]), 0);
    end_check(g);
  endtask

  task automatic run_suite(input int g);
    logic [31:0] w;
    do_reset(g);
    // single count-3 word with back-to-back acceptance
    timed_word(g, 32'h0C33_2211, 3);
    // count-0 word is consumed silently
    tx_ready[g] = 1'b1;
    enable[g]   = 1'b1;
    push_word(g, 32'h00AA_BBCC, 1'b1);
    push_word(g, 32'h0400_00EE, 1'b1);
    wait_drain(g, 50);
    end_check(g);
    // transmitter stalls on the first byte
    tx_ready[g] = 1'b0;
    push_word(g, rand_word(2), 1'b1);
    wait_valid(g);
    for (int i = 0; i < 5; i++) cycle();
    tx_ready[g] = 1'b1;
    wait_drain(g, 50);
    end_check(g);
    // flush on the second handshake of a 3-byte word
    w = rand_word(3);
    push_word(g, w, 1'b0);
    expect_byte(g, w[7:0]);
    expect_byte(g, w[15:8]);
    wait_valid(g);
    flush[g] = 1'b1;
    cycle();
    flush[g] = 1'b0;
    cycle();
    check_eq(tag("flush_send_busy", g), 32'(s_busy[g]), 0);
    check_eq(tag("flush_send_valid", g), 32'(s_valid[g]), 0);
    wait_drain(g, 50);
    end_check(g);
    // flush in FETCH and in LOAD
    flush_at(g, 1);
    flush_at(g, lat(g) + 1);
    // enable drops during the first of two queued words
    push_word(g, rand_word(2), 1'b1);
    push_word(g, rand_word(3), 1'b1);
    wait_pop(g);
    enable[g] = 1'b0;
    wait_drain(g, 50);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq(tag("no_pop_disabled", g), 32'(s_rden[g]), 0);
    end
    check_eq(tag("fifo_words_left", g), fifo_wr[g] - fifo_rd[g], 1);
    enable[g] = 1'b1;
    wait_drain(g, 50);
    end_check(g);
    // random traffic with random back-pressure
    for (int i = 0; i < 24; i++) push_word(g, rand_word($urandom_range(3)), 1'b1);
    for (int c = 0; c < 1500; c++) begin
      tx_ready[g] = ($urandom_range(3) != 0);
      cycle();
      if (!s_busy[g] && fifo_empty[g]) break;
    end
    tx_ready[g] = 1'b1;
    wait_drain(g, 100);
    end_check(g);
    // 17 bytes from reset exercises the counter wrap on the narrow instance
    do_reset(g);
    tx_ready[g] = 1'b1;
    enable[g]   = 1'b1;
    for (int i = 0; i < 5; i++) push_word(g, rand_word(3), 1'b1);
    push_word(g, rand_word(2), 1'b1);
    wait_drain(g, 200);
    end_check(g);
    // reset while a byte is being offered
    tx_ready[g] = 1'b0;
    push_word(g, rand_word(3), 1'b0);
    wait_valid(g);
    do_reset(g);
    for (int i = 0; i < 5; i++) cycle();
    end_check(g);
  endtask

  initial begin
    rst      = 2'b11;
    enable   = 2'b00;
    flush    = 2'b00;
    tx_ready = 2'b00;
    for (int g = 0; g < NumDut; g++) begin
      exp_wr[g]     = 0;
      exp_rd[g]     = 0;
      exp_total[g]  = 0;
      prev_stall[g] = 1'b0;
      prev_data[g]  = 8'h00;
    end
    for (int g = 0; g < NumDut; g++) run_suite(g);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish, errors so far %0d", n_errors);
    $fatal(1, "bench timed out");
  end

endmodule
